// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC accumulation stage.
//   state_t    : FSM state encoding (IDLE, ACCUM, DONE)
//   ACC_W_DEF  : default accumulator / result width
//   CNT_W_DEF  : default term-count width
//   PROD_W     : width of the product delivered by the multiplier stage
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 80;
  localparam int CNT_W_DEF = 16;
  localparam int PROD_W    = 64;

endpackage

// File: rtl/mac_ext_add.sv
// mac_ext_add: extends a 64-bit product to ACC_W bits, signed or unsigned,
// adds it to the accumulator modulo 2^ACC_W, and flags signed overflow.
//   i_acc     : current accumulator value
//   i_product : product from the multiplier stage
//   i_sign    : 1 = sign-extend i_product, 0 = zero-extend
//   o_sum     : i_acc + ext(i_product), wrapped to ACC_W bits
//   o_ovf     : operands share a sign bit and the sum's sign bit differs
module mac_ext_add
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_product,
  input  logic              i_sign,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic             w_fill;
  logic [ACC_W-1:0] w_ext;

  assign w_fill = i_sign & i_product[PROD_W-1];
  assign w_ext  = {{(ACC_W-PROD_W){w_fill}}, i_product};
  assign o_sum  = i_acc + w_ext;
  assign o_ovf  = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                  (o_sum[ACC_W-1] != i_acc[ACC_W-1]);

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sums a programmed number of 64-bit products into a wide
// two's-complement accumulator and presents the result under valid/ready.
//   i_clk, i_rstn : clock, async active-low reset
//   i_start/i_len : job start pulse and term count (sampled in IDLE only)
//   i_prod_vld/i_prod_sign/i_product, o_prod_rdy : product stream
//   o_acc_vld/i_acc_rdy, o_acc, o_ovf : result handshake, sum, sticky overflow
//   o_busy : state is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start; o_acc still shows the previous result
// ST_ACCUM | accepting products, r_rem counts the terms still owed
// ST_DONE  | result valid and frozen until i_acc_rdy
module mac_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_prod_vld,
  input  logic              i_prod_sign,
  input  logic [PROD_W-1:0] i_product,
  output logic              o_prod_rdy,
  output logic              o_acc_vld,
  input  logic              i_acc_rdy,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf,
  output logic              o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_rem;

  logic             w_accept;
  logic             w_load;
  logic             w_prod_rdy;
  logic             w_acc_vld;
  logic [ACC_W-1:0] w_sum;
  logic             w_sum_ovf;

  mac_ext_add #(.ACC_W(ACC_W)) u_ext_add (
    .i_acc     (r_acc),
    .i_product (i_product),
    .i_sign    (i_prod_sign),
    .o_sum     (w_sum),
    .o_ovf     (w_sum_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prod_rdy  = 1'b0;
    w_acc_vld   = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = (i_len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        w_prod_rdy = 1'b1;
        if (i_prod_vld) begin
          w_accept = 1'b1;
          if (r_rem == CNT_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_acc_vld = 1'b1;
        if (i_acc_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Start clears the sum so a zero-length job reports 0; otherwise the
  // last result stays visible through IDLE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if (w_load) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= i_len;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_sum_ovf;
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign o_prod_rdy = w_prod_rdy;
  assign o_acc_vld  = w_acc_vld;
  assign o_acc      = r_acc;
  assign o_ovf      = r_ovf;
  assign o_busy     = (r_state != ST_IDLE);

endmodule
